// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: response-owner encoding and default widths.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    // Only reads produce a response; a store leaves no owner behind.
    function automatic owner_t next_owner(input logic fetch_gnt, input logic data_gnt,
                                          input logic data_we);
        owner_t own;
        if (fetch_gnt) begin
            own = OWN_FETCH;
        end else if (data_gnt && !data_we) begin
            own = OWN_DATA;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive denied fetch cycles; at_max forces fetch ahead of data.
module starve_counter #(
    parameter int MAX_STALL = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_STALL);

    logic [CW-1:0] cnt_r;

    // Clear wins over increment; the count holds once it reaches MAX_STALL.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_max = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: loader in load mode, data-over-fetch in run mode with
// starvation override, and 1-cycle read responses routed back to the issuer.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_STALL = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              working,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wEn,
    output logic              ram_rEn,
    output logic [DATA_W-1:0] ram_wDat,
    input  logic [DATA_W-1:0] ram_rDat
);

    owner_t owner_r;
    logic   d_err_r;
    logic   fetch_win_s;
    logic   data_win_s;
    logic   starve_inc_s;
    logic   starve_at_max_s;
    logic   oob_s;

    // Fetch normally yields to data; it wins only when data is idle or it has waited MAX_STALL cycles.
    assign fetch_win_s  = working & if_req & (starve_at_max_s | ~d_req);
    assign data_win_s   = working & d_req & ~fetch_win_s;
    assign starve_inc_s = working & if_req & ~fetch_win_s;
    assign oob_s        = |d_addr[31:ADDR_W];

    assign if_gnt = fetch_win_s;
    assign d_gnt  = data_win_s;

    starve_counter #(
        .MAX_STALL(MAX_STALL)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (starve_inc_s),
        .clr   (~starve_inc_s),
        .at_max(starve_at_max_s)
    );

    // Drive the RAM in the grant cycle; an idle cycle presents all-zero controls.
    always_comb begin
        ram_addr = {ADDR_W{1'b0}};
        ram_wEn  = 1'b0;
        ram_rEn  = 1'b0;
        ram_wDat = {DATA_W{1'b0}};
        if (!working) begin
            if (ld_wr) begin
                ram_wEn  = 1'b1;
                ram_addr = ld_addr;
                ram_wDat = ld_wdata;
            end else begin
                ram_wEn = 1'b0;
            end
        end else if (fetch_win_s) begin
            ram_rEn  = 1'b1;
            ram_addr = if_addr;
        end else if (data_win_s) begin
            ram_addr = d_addr[ADDR_W-1:0];
            if (d_we) begin
                ram_wEn  = 1'b1;
                ram_wDat = d_wdata;
            end else begin
                ram_rEn = 1'b1;
            end
        end else begin
            ram_rEn = 1'b0;
        end
    end

    // Remember who issued this cycle's read so the next cycle's RAM data goes to them.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r <= OWN_NONE;
            d_err_r <= 1'b0;
        end else begin
            owner_r <= next_owner(fetch_win_s, data_win_s, d_we);
            d_err_r <= data_win_s & oob_s;
        end
    end

    assign if_rvalid = (owner_r == OWN_FETCH);
    assign d_rvalid  = (owner_r == OWN_DATA);
    assign if_rdata  = if_rvalid ? ram_rDat : {DATA_W{1'b0}};
    assign d_rdata   = d_rvalid ? ram_rDat : {DATA_W{1'b0}};
    assign d_err     = d_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, reference memory and response queues.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset, working, ld_wr, if_req, d_req, d_we;
    logic [8:0]  ld_addr, if_addr, ram_addr;
    logic [31:0] ld_wdata, d_addr, d_wdata, ram_wDat, ram_rDat;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, ram_wEn, ram_rEn;
    logic [31:0] if_rdata, d_rdata;

    logic [31:0] mem [0:511];
    logic [31:0] ref_mem [0:15];
    logic [31:0] fetch_q [$];
    logic [31:0] data_q [$];
    logic [31:0] exp_v;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    mem_arbiter dut (
        .clock(clock), .reset(reset), .working(working),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wEn(ram_wEn), .ram_rEn(ram_rEn),
        .ram_wDat(ram_wDat), .ram_rDat(ram_rDat)
    );

    always #5 clock = ~clock;

    // Behavioural RAM with 1-cycle read latency
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_wDat;
        if (ram_rEn) ram_rDat <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clock);
        total_cnt++;
        if ({if_rvalid, d_rvalid, d_err, if_rdata, d_rdata, ram_wEn, ram_rEn} !== 69'd0)
            $display("FAIL reset_outputs got %b/%b/%b/%h/%h/%b/%b exp all 0",
                     if_rvalid, d_rvalid, d_err, if_rdata, d_rdata, ram_wEn, ram_rEn);
        else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        working = 1'b0;
        if_req = 1'b1; if_addr = 9'd3; d_req = 1'b1; d_addr = 32'd3;
        for (int i = 0; i < 16; i++) begin
            ld_wr = 1'b1;
            ld_addr = 9'(i);
            ld_wdata = (i == 5) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
            ref_mem[i] = ld_wdata;
            @(negedge clock);
            total_cnt++;
            if ({ram_wEn, ram_rEn, ram_addr, ram_wDat, if_gnt, d_gnt} !== {1'b1, 1'b0, ld_addr, ld_wdata, 2'b00})
                $display("FAIL load_write[%0d] got wEn=%b rEn=%b addr=%0d dat=%h gnt=%b%b exp wEn=1 addr=%0d dat=%h gnt=00",
                         i, ram_wEn, ram_rEn, ram_addr, ram_wDat, if_gnt, d_gnt, ld_addr, ld_wdata);
            else pass_cnt++;
            tick();
        end
        ld_wr = 1'b0; ld_addr = 9'd0; ld_wdata = 32'd0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clock);
        total_cnt++;
        if ({ram_wEn, ram_rEn, ram_addr, ram_wDat, if_rvalid, d_rvalid} !== 45'd0)
            $display("FAIL load_idle got wEn=%b rEn=%b addr=%0d dat=%h rv=%b%b exp all 0",
                     ram_wEn, ram_rEn, ram_addr, ram_wDat, if_rvalid, d_rvalid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_fetch();
        working = 1'b1; if_req = 1'b1; if_addr = 9'd5;
        @(negedge clock);
        total_cnt++;
        if ({if_gnt, d_gnt, ram_rEn, ram_wEn, ram_addr} !== {4'b1010, 9'd5})
            $display("FAIL fetch_gnt got gnt=%b%b rEn=%b wEn=%b addr=%0d exp gnt=10 rEn=1 wEn=0 addr=5",
                     if_gnt, d_gnt, ram_rEn, ram_wEn, ram_addr);
        else pass_cnt++;
        fetch_q.push_back(ref_mem[5]);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        exp_v = fetch_q.pop_front();
        total_cnt++;
        if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, exp_v})
            $display("FAIL fetch_rvalid got rv=%b%b data=%h exp rv=10 data=%h",
                     if_rvalid, d_rvalid, if_rdata, exp_v);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 9'd2; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd5;
        @(negedge clock);
        total_cnt++;
        if ({d_gnt, if_gnt, ram_rEn, ram_addr} !== {3'b101, 9'd5})
            $display("FAIL contention_gnt got d=%b if=%b rEn=%b addr=%0d exp d=1 if=0 rEn=1 addr=5",
                     d_gnt, if_gnt, ram_rEn, ram_addr);
        else pass_cnt++;
        data_q.push_back(ref_mem[5]);
        tick();
        d_req = 1'b0;
        @(negedge clock);
        exp_v = data_q.pop_front();
        total_cnt++;
        if ({d_rvalid, if_rvalid, d_rdata} !== {2'b10, exp_v})
            $display("FAIL contention_drvalid got rv=%b%b data=%h exp rv=10 data=%h",
                     d_rvalid, if_rvalid, d_rdata, exp_v);
        else pass_cnt++;
        total_cnt++;
        if ({if_gnt, ram_addr} !== {1'b1, 9'd2})
            $display("FAIL contention_fetch_next got if_gnt=%b addr=%0d exp if_gnt=1 addr=2", if_gnt, ram_addr);
        else pass_cnt++;
        fetch_q.push_back(ref_mem[2]);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        exp_v = fetch_q.pop_front();
        total_cnt++;
        if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, exp_v})
            $display("FAIL contention_ifrvalid got rv=%b%b data=%h exp rv=10 data=%h",
                     if_rvalid, d_rvalid, if_rdata, exp_v);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_starvation();
        bit exp_f, exp_d, prev_f, prev_d;
        prev_f = 1'b0; prev_d = 1'b0;
        if_addr = 9'd3; d_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if_req = (c < 11);
            d_req = (c < 11);
            d_addr = 32'(c);
            exp_f = (c == 4) || (c == 9);
            exp_d = (c < 11) && !exp_f;
            @(negedge clock);
            total_cnt++;
            if ({if_gnt, d_gnt} !== {exp_f, exp_d})
                $display("FAIL starve_gnt[%0d] got if=%b d=%b exp if=%b d=%b", c, if_gnt, d_gnt, exp_f, exp_d);
            else pass_cnt++;
            total_cnt++;
            if ({if_rvalid, d_rvalid} !== {prev_f, prev_d})
                $display("FAIL starve_rvalid[%0d] got %b%b exp %b%b", c, if_rvalid, d_rvalid, prev_f, prev_d);
            else pass_cnt++;
            if (prev_f) begin
                exp_v = fetch_q.pop_front();
                total_cnt++;
                if (if_rdata !== exp_v) $display("FAIL starve_ifdata[%0d] got %h exp %h", c, if_rdata, exp_v);
                else pass_cnt++;
            end
            if (prev_d) begin
                exp_v = data_q.pop_front();
                total_cnt++;
                if (d_rdata !== exp_v) $display("FAIL starve_ddata[%0d] got %h exp %h", c, d_rdata, exp_v);
                else pass_cnt++;
            end
            if (exp_f) fetch_q.push_back(ref_mem[3]);
            if (exp_d) data_q.push_back(ref_mem[c]);
            prev_f = exp_f; prev_d = exp_d;
            tick();
        end
    endtask

    task automatic test_drop();
        bit exp_f;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd1; if_addr = 9'd4;
        for (int k = 0; k < 9; k++) begin
            if_req = (k != 3);
            exp_f = (k == 8);
            @(negedge clock);
            total_cnt++;
            if (if_gnt !== exp_f) $display("FAIL drop_gnt[%0d] got %b exp %b", k, if_gnt, exp_f);
            else pass_cnt++;
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h1234_5678;
        @(negedge clock);
        total_cnt++;
        if ({d_gnt, ram_wEn, ram_rEn, ram_addr, ram_wDat} !== {3'b110, 9'd7, 32'h1234_5678})
            $display("FAIL store_issue got gnt=%b wEn=%b rEn=%b addr=%0d dat=%h exp 1/1/0/7/12345678",
                     d_gnt, ram_wEn, ram_rEn, ram_addr, ram_wDat);
        else pass_cnt++;
        ref_mem[7] = 32'h1234_5678;
        tick();
        d_we = 1'b0;
        @(negedge clock);
        total_cnt++;
        if ({d_rvalid, d_gnt, ram_rEn} !== 3'b011)
            $display("FAIL store_no_rvalid got rv=%b gnt=%b rEn=%b exp rv=0 gnt=1 rEn=1", d_rvalid, d_gnt, ram_rEn);
        else pass_cnt++;
        data_q.push_back(ref_mem[7]);
        tick();
        d_req = 1'b0;
        @(negedge clock);
        exp_v = data_q.pop_front();
        total_cnt++;
        if ({d_rvalid, d_rdata} !== {1'b1, exp_v})
            $display("FAIL load_after_store got rv=%b data=%h exp rv=1 data=%h", d_rvalid, d_rdata, exp_v);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_err();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        @(negedge clock);
        total_cnt++;
        if ({d_gnt, ram_rEn, ram_addr, d_err} !== {2'b11, 9'd0, 1'b0})
            $display("FAIL err_issue got gnt=%b rEn=%b addr=%0d err=%b exp 1/1/0/0", d_gnt, ram_rEn, ram_addr, d_err);
        else pass_cnt++;
        data_q.push_back(ref_mem[0]);
        tick();
        d_addr = 32'd1;
        @(negedge clock);
        exp_v = data_q.pop_front();
        total_cnt++;
        if ({d_err, d_rvalid, d_rdata} !== {2'b11, exp_v})
            $display("FAIL err_flag got err=%b rv=%b data=%h exp err=1 rv=1 data=%h", d_err, d_rvalid, d_rdata, exp_v);
        else pass_cnt++;
        data_q.push_back(ref_mem[1]);
        tick();
        d_req = 1'b0;
        @(negedge clock);
        exp_v = data_q.pop_front();
        total_cnt++;
        if ({d_err, d_rvalid, d_rdata} !== {2'b01, exp_v})
            $display("FAIL err_clear got err=%b rv=%b data=%h exp err=0 rv=1 data=%h", d_err, d_rvalid, d_rdata, exp_v);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_working_fall();
        if_req = 1'b1; if_addr = 9'd6;
        @(negedge clock);
        total_cnt++;
        if (if_gnt !== 1'b1) $display("FAIL wfall_gnt got %b exp 1", if_gnt);
        else pass_cnt++;
        fetch_q.push_back(ref_mem[6]);
        tick();
        working = 1'b0;
        @(negedge clock);
        exp_v = fetch_q.pop_front();
        total_cnt++;
        if ({if_rvalid, if_gnt, if_rdata} !== {2'b10, exp_v})
            $display("FAIL wfall_rvalid got rv=%b gnt=%b data=%h exp rv=1 gnt=0 data=%h", if_rvalid, if_gnt, if_rdata, exp_v);
        else pass_cnt++;
        tick();
        working = 1'b1; if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 9'd5;
        @(negedge clock);
        total_cnt++;
        if (if_gnt !== 1'b1) $display("FAIL rmid_gnt got %b exp 1", if_gnt);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        if_req = 1'b0;
        @(negedge clock);
        total_cnt++;
        if ({if_rvalid, d_rvalid, d_err, if_rdata, d_rdata} !== 67'd0)
            $display("FAIL rmid_dropped got rv=%b%b err=%b data=%h/%h exp all 0", if_rvalid, d_rvalid, d_err, if_rdata, d_rdata);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        @(negedge clock);
        total_cnt++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b000)
            $display("FAIL rmid_after got rv=%b%b err=%b exp 000", if_rvalid, d_rvalid, d_err);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        reset = 1'b1; working = 1'b0; ld_wr = 1'b0; ld_addr = 9'd0; ld_wdata = 32'd0;
        if_req = 1'b0; if_addr = 9'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        test_reset();
        test_load();
        test_fetch();
        test_contention();
        test_starvation();
        test_drop();
        test_store_load();
        test_err();
        test_working_fall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single shared instruction/data RAM between three requesters: the top-level program loader, the pipeline's data-memory stage (load/store), and instruction fetch. The block issues at most one RAM access per cycle and routes the 1-cycle-latency read data back to whichever requester issued it, with a valid pulse. Fetch is protected from data-port starvation. It sits between the pipeline stages and the `ram` instance, replacing ad-hoc address/enable muxing.

## Interface
Parameters:
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, data width
- MAX_STALL, 4, consecutive denied fetch cycles before fetch is forced ahead of data (≥1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- working  in  1  1 = run mode (fetch/data served), 0 = load mode (loader only)
- ld_wr  in  1  loader write strobe
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- if_req  in  1  fetch read request, held until granted
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  DATA_W  fetch data, 0 when if_rvalid=0
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte-agnostic word address from ALU (valE)
- d_wdata  in  DATA_W  store data (valA)
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered)
- d_rdata  out  DATA_W  load data, 0 when d_rvalid=0
- d_err  out  1  registered; pulses 1 cycle after a data grant whose d_addr[31:ADDR_W] ≠ 0
- ram_addr  out  ADDR_W  to ram addr
- ram_wEn  out  1  to ram wEn
- ram_rEn  out  1  to ram rEn
- ram_wDat  out  DATA_W  to ram wDat
- ram_rDat  in  DATA_W  from ram rDat, valid 1 cycle after read issue

## Operation
- Load mode (working=0): ld_wr → ram_wEn=1, ram_addr=ld_addr, ram_wDat=ld_wdata. if_gnt=d_gnt=0. ld_* ignored in run mode.
- Run mode priority: data > fetch, except when starve_cnt==MAX_STALL and if_req=1 → fetch wins.
- Grant drives RAM in the same cycle: fetch → ram_rEn=1, ram_addr=if_addr. Data load → ram_rEn=1, addr=d_addr[ADDR_W-1:0]. Data store → ram_wEn=1, ram_wDat=d_wdata, ram_rEn=0.
- No grant → ram_wEn=ram_rEn=0, ram_addr=0, ram_wDat=0.
- Response owner register: NONE / FETCH / DATA, loaded each cycle from the issuing read (stores load NONE). Next cycle: owner FETCH → if_rvalid=1, if_rdata=ram_rDat; owner DATA → d_rvalid=1, d_rdata=ram_rDat.
- Out-of-range d_addr: access still performed on truncated address; d_err flags it.
- starve_cnt: +1 (saturating at MAX_STALL) each run-mode cycle with if_req=1 and if_gnt=0; cleared on if_gnt, if_req=0, or working=0.

## Timing
- Reset: owner=NONE, starve_cnt=0; if_rvalid, d_rvalid, d_err, if_rdata, d_rdata = 0. Combinational outputs follow inputs from the first cycle after reset.
- Read latency: rvalid exactly 1 cycle after gnt; back-to-back grants give back-to-back rvalids, one per cycle.
- Store: no rvalid; write occurs on the grant edge.
- working falling with a read outstanding: response still delivered next cycle.
- Reset concurrent with an outstanding read: response dropped, rvalid stays 0.
- Requester dropping req without gnt: allowed; no side effects.

## Structure
- Shared package: owner encoding (OWN_NONE/OWN_FETCH/OWN_DATA), default ADDR_W/DATA_W.
- One sub-module natural: `starve_counter` (saturating counter with clear, MAX_STALL compare output).

## Test plan
- Load mode: ld_wr=1, ld_addr=5, ld_wdata=0xDEADBEEF; then run mode, if_req addr 5 → if_gnt same cycle, if_rvalid next cycle with if_rdata=0xDEADBEEF.
- Contention: if_req and d_req (load, addr 5) same cycle → d_gnt=1, if_gnt=0; next cycle d_rvalid=1, data 0xDEADBEEF; fetch granted the cycle after.
- Starvation: d_req held continuously, if_req held, MAX_STALL=4 → if_gnt=1 on the 5th cycle, then data resumes.
- Store then load: d_we=1 addr 7 data 0x12345678, then load addr 7 → d_rvalid with 0x12345678; no rvalid for the store.
- d_addr=0x200 → d_err=1 one cycle after grant, access on addr 0.
- Reset asserted the cycle after a fetch grant → if_rvalid=0, all outputs at reset values.
